// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  localparam int          INSTR_W   = 16;
  localparam logic [15:0] HLT_INSTR = 16'hF000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Registered response: captured on the acceptance edge.
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic               err;
  } rsp_t;

endpackage

// File: rtl/imem_responder_if.sv
// Fetch request/response handshake plus the program-load port.
interface imem_responder_if #(
  parameter int DEPTH_LOG2 = 10
);
  import imem_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic [15:0]           req_addr;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [INSTR_W-1:0]    rsp_instr;
  logic                  rsp_err;
  logic                  ld_we;
  logic [DEPTH_LOG2-1:0] ld_addr;
  logic [INSTR_W-1:0]    ld_data;

  // Responder side.
  modport slave (
    input  req_valid, req_addr, rsp_ready, ld_we, ld_addr, ld_data,
    output req_ready, rsp_valid, rsp_instr, rsp_err
  );

  // Requester / loader side.
  modport master (
    output req_valid, req_addr, rsp_ready, ld_we, ld_addr, ld_data,
    input  req_ready, rsp_valid, rsp_instr, rsp_err
  );

endinterface

// File: rtl/imem_array.sv
// Instruction storage: synchronous write, combinational read, no reset.
module imem_array
  import imem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [DEPTH_LOG2-1:0] i_waddr,
  input  logic [INSTR_W-1:0]    i_wdata,
  input  logic [DEPTH_LOG2-1:0] i_raddr,
  output logic [INSTR_W-1:0]    o_rdata
);

  logic [INSTR_W-1:0] r_mem [2**DEPTH_LOG2];

  // Program-load write; contents survive reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/imem_responder.sv
// Single-outstanding instruction fetch responder with fixed LATENCY.
// Optional macro IMEM_ALIGN_CHECK_EN: odd byte addresses return an error.
module imem_responder
  import imem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input logic             clk,
  input logic             rst_n,
  imem_responder_if.slave bus
);

  state_t                r_state, w_state_nxt;
  logic [3:0]            r_cnt, w_cnt_nxt;
  rsp_t                  r_rsp, w_rsp;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic [INSTR_W-1:0]    w_rdata;
  logic                  w_oor, w_mis, w_accept;

  assign w_idx = bus.req_addr[DEPTH_LOG2:1];

  // Any address bit above the array's byte range marks the fetch out of range.
  generate
    if (DEPTH_LOG2 < 15) begin : g_oor
      assign w_oor = |bus.req_addr[15:DEPTH_LOG2+1];
    end else begin : g_no_oor
      assign w_oor = 1'b0;
    end
  endgenerate

`ifdef IMEM_ALIGN_CHECK_EN
  assign w_mis = bus.req_addr[0];
`else
  assign w_mis = 1'b0;
`endif

  imem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk     (clk),
    .i_we    (bus.ld_we),
    .i_waddr (bus.ld_addr),
    .i_wdata (bus.ld_data),
    .i_raddr (w_idx),
    .o_rdata (w_rdata)
  );

  assign w_accept  = bus.req_valid && (r_state == IDLE);
  assign w_rsp     = (w_oor || w_mis) ? '{instr: HLT_INSTR, err: 1'b1}
                                      : '{instr: w_rdata,   err: 1'b0};

  assign bus.req_ready = (r_state == IDLE);
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.rsp_instr = bus.rsp_valid ? r_rsp.instr : '0;
  assign bus.rsp_err   = bus.rsp_valid && r_rsp.err;

  // Next-state and latency counter: WAIT counts down to 1 then presents.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = 4'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (r_cnt == 4'd1) begin
          w_state_nxt = RESP;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_cnt_nxt   = r_cnt - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 4'd0;
      end
    endcase
  end

  // State register; reset drops any pending response immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Capture the word on acceptance so later loads cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_rsp <= '0;
    else if (w_accept) r_rsp <= w_rsp;
  end

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder: posedge model pushes expected
// responses, negedge monitor compares every DUT output.
module tb_imem_responder;
  import imem_pkg::*;

  localparam int DL  = 10;
  localparam int LAT = 2;
  localparam int NW  = 2**DL;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  imem_responder_if #(.DEPTH_LOG2(DL)) bus ();
  imem_responder #(.DEPTH_LOG2(DL), .LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  logic [15:0] mem [NW];
  rsp_t q [$];
  bit   busy = 0;
  int   ec = 0;
  int   t_acc = 0;

  function automatic rsp_t model_rsp(input logic [15:0] addr);
    rsp_t r;
    bit   bad;
    bad = ((32'(addr) >> (DL + 1)) != 0);
`ifdef IMEM_ALIGN_CHECK_EN
    if (addr[0]) bad = 1;
`endif
    if (bad) begin r.instr = 16'hF000; r.err = 1'b1; end
    else     begin r.instr = mem[addr[DL:1]]; r.err = 1'b0; end
    return r;
  endfunction

  // Reference model: one fetch outstanding, visible LAT cycles after acceptance.
  always @(posedge clk) begin
    if (!rst_n) begin
      busy = 0;
      q.delete();
    end else if (busy && (ec - t_acc >= LAT) && bus.rsp_ready) begin
      busy = 0;
    end else if (!busy && bus.req_valid) begin
      q.push_back(model_rsp(bus.req_addr));
      busy  = 1;
      t_acc = ec;
    end
    if (bus.ld_we === 1'b1) mem[bus.ld_addr] = bus.ld_data;
    ec++;
  end

  // Monitor: compare handshake outputs and payload against the model.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      bit ev;
      ev = busy && (ec - t_acc >= LAT);
      checks++;
      if (bus.req_ready !== !busy) begin
        errors++;
        $display("FAIL req_ready t=%0t got=%b exp=%b", $time, bus.req_ready, !busy);
      end
      checks++;
      if (bus.rsp_valid !== ev) begin
        errors++;
        $display("FAIL rsp_valid t=%0t got=%b exp=%b", $time, bus.rsp_valid, ev);
      end
      if (ev && bus.rsp_valid === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rsp_payload t=%0t got=%h/%b exp=none", $time, bus.rsp_instr, bus.rsp_err);
        end else begin
          if (bus.rsp_instr !== q[0].instr || bus.rsp_err !== q[0].err) begin
            errors++;
            $display("FAIL rsp_payload t=%0t got=%h/%b exp=%h/%b", $time,
                     bus.rsp_instr, bus.rsp_err, q[0].instr, q[0].err);
          end
          if (bus.rsp_ready === 1'b1) void'(q.pop_front());
        end
      end else if (bus.rsp_valid !== 1'b1) begin
        checks++;
        if (bus.rsp_instr !== 16'h0 || bus.rsp_err !== 1'b0) begin
          errors++;
          $display("FAIL idle_zero t=%0t got=%h/%b exp=0000/0", $time, bus.rsp_instr, bus.rsp_err);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic load(input int idx, input logic [15:0] d);
    bus.ld_we = 1; bus.ld_addr = DL'(idx); bus.ld_data = d;
    step();
    bus.ld_we = 0;
  endtask

  // Issue one fetch (optionally with a same-edge load), hold rsp_ready low
  // for 'hold' cycles of RESP, then complete the handshake.
  task automatic fetch(input logic [15:0] addr, input int hold, input bit wr,
                       input int wa, input logic [15:0] wd);
    int n;
    n = 0;
    while (busy && n < 100) begin step(); n++; end
    bus.req_valid = 1; bus.req_addr = addr; bus.rsp_ready = (hold == 0);
    bus.ld_we = wr; bus.ld_addr = DL'(wa); bus.ld_data = wd;
    step();
    bus.req_valid = 0; bus.ld_we = 0;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 100) begin step(); n++; end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL fetch_timeout addr=%h got=no rsp_valid exp=rsp_valid", addr);
    end
    repeat (hold) step();
    bus.rsp_ready = 1;
    step();
    bus.rsp_ready = 0;
  endtask

  initial begin
    rst_n = 0;
    bus.req_valid = 0; bus.req_addr = '0; bus.rsp_ready = 0;
    bus.ld_we = 0; bus.ld_addr = '0; bus.ld_data = '0;
    #1;
    checks++;
    if (bus.rsp_valid !== 0 || bus.rsp_instr !== 0 || bus.rsp_err !== 0 || bus.req_ready !== 1) begin
      errors++;
      $display("FAIL reset_state got=v%b i%h e%b r%b exp=v0 i0000 e0 r1",
               bus.rsp_valid, bus.rsp_instr, bus.rsp_err, bus.req_ready);
    end
    repeat (2) step();
    rst_n = 1;
    step();

    for (int i = 0; i < NW; i++) load(i, 16'($urandom));

    load(3, 16'h1234);
    fetch(16'h0006, 0, 0, 0, 0);             // basic word fetch
    fetch(16'h0800, 0, 0, 0, 0);             // out of range
    fetch(16'hFFFE, 0, 0, 0, 0);             // far out of range
    fetch(16'h07FE, 0, 0, 0, 0);             // last word
    fetch(16'h0000, 5, 0, 0, 0);             // stall in RESP
    load(4, 16'hAAAA);
    fetch(16'h0008, 0, 1, 4, 16'h5555);      // read-before-write
    fetch(16'h0008, 0, 0, 0, 0);             // sees new data
    fetch(16'h0003, 0, 0, 0, 0);             // odd address

    // Reset while in WAIT: pending response must vanish.
    bus.req_valid = 1; bus.req_addr = 16'h0006; bus.rsp_ready = 1;
    step();
    bus.req_valid = 0;
    rst_n = 0;
    #1;
    checks++;
    if (bus.req_ready !== 1 || bus.rsp_valid !== 0 || bus.rsp_instr !== 0 || bus.rsp_err !== 0) begin
      errors++;
      $display("FAIL async_reset got=r%b v%b i%h e%b exp=r1 v0 i0000 e0",
               bus.req_ready, bus.rsp_valid, bus.rsp_instr, bus.rsp_err);
    end
    repeat (2) step();
    rst_n = 1;
    repeat (6) step();
    fetch(16'h0006, 0, 0, 0, 0);

    // Random traffic: requests while busy, random backpressure and loads.
    for (int c = 0; c < 3000; c++) begin
      bus.req_valid = ($urandom_range(0, 1) == 1);
      bus.req_addr  = ($urandom_range(0, 9) == 0) ? 16'($urandom)
                                                  : 16'($urandom_range(0, 2*NW - 1));
      bus.rsp_ready = ($urandom_range(0, 9) < 7);
      bus.ld_we     = ($urandom_range(0, 4) == 0);
      bus.ld_addr   = DL'($urandom_range(0, NW - 1));
      bus.ld_data   = 16'($urandom);
      step();
    end
    bus.req_valid = 0; bus.ld_we = 0; bus.rsp_ready = 1;
    repeat (10) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
IMEM_RESPONDER -- requirements
Module: imem_responder

Interface
REQ-001 Parameter DEPTH_LOG2, default 10: memory holds 2^DEPTH_LOG2 16-bit instruction words.
REQ-002 Parameter LATENCY, default 2, legal 1..15: cycles from request acceptance to rsp_valid.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 req_valid  input  1  fetch request present.
REQ-006 req_ready  output  1  responder can accept a request.
REQ-007 req_addr  input  16  byte address of fetch; word index = req_addr[DEPTH_LOG2:1].
REQ-008 rsp_valid  output  1  response present.
REQ-009 rsp_ready  input  1  requester consumes the response.
REQ-010 rsp_instr  output  16  fetched instruction word.
REQ-011 rsp_err  output  1  fetch was out of range or misaligned.
REQ-012 ld_we  input  1  program-load write enable.
REQ-013 ld_addr  input  DEPTH_LOG2  program-load word index.
REQ-014 ld_data  input  16  program-load data.

Function
REQ-015 The FSM SHALL have three states, IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 A request is accepted on the edge where req_valid && req_ready.
REQ-017 On acceptance, the memory word SHALL be read and registered on that same edge; later ld_we writes SHALL NOT alter the pending response.
REQ-018 Acceptance transitions: LATENCY=1 goes IDLE->RESP; LATENCY>1 goes IDLE->WAIT and loads a down-counter with LATENCY-1.
REQ-019 WAIT SHALL decrement the counter each cycle and move to RESP when the counter reaches 1, so rsp_valid rises exactly LATENCY cycles after acceptance.
REQ-020 In RESP, rsp_valid=1, and rsp_instr and rsp_err SHALL stay stable until rsp_ready=1; the responder then returns to IDLE on that edge.
REQ-021 The next acceptance is possible no earlier than one cycle after the handshake; peak throughput is one fetch per LATENCY+1 cycles.
REQ-022 When rsp_valid=0, rsp_instr and rsp_err SHALL be 0.
REQ-023 Out of range (req_addr[15:DEPTH_LOG2+1] != 0): rsp_err=1, rsp_instr=HLT_INSTR (16'hF000).
REQ-024 ld_we writes ld_data to ld_addr at the edge, in any state.
REQ-025 ld_we and acceptance on the same edge, same word: the response SHALL return the old data (read-before-write).
REQ-026 req_valid held while not in IDLE SHALL be ignored and not queued.
REQ-027 The counter SHALL be 4 bits; no wrap-around occurs for legal LATENCY.

Reset
REQ-028 On rst_n=0, state SHALL become IDLE immediately; counter=0; rsp_valid=0; rsp_instr=0; rsp_err=0; req_ready=1 once rst_n=1.
REQ-029 Reset in WAIT or RESP SHALL discard the pending response with no rsp_valid pulse.
REQ-030 Memory contents SHALL NOT be reset.

Configuration
REQ-031 Macro IMEM_ALIGN_CHECK_EN: defined, req_addr[0]=1 yields rsp_err=1 and rsp_instr=HLT_INSTR; undefined, req_addr[0] is ignored and the fetch proceeds normally.

Structure
REQ-032 Package imem_pkg SHALL hold the state enum (IDLE, WAIT, RESP), HLT_INSTR=16'hF000 and the instruction width constant 16.
REQ-033 Sub-module imem_array SHALL implement the storage: synchronous write, combinational read, DEPTH_LOG2 parameter.

Verification
REQ-034 Load word 3 = 16'h1234; LATENCY=2; request req_addr=16'h0006 with rsp_ready=1 -> rsp_valid two cycles after acceptance, rsp_instr=16'h1234, rsp_err=0.
REQ-035 With DEPTH_LOG2=10, request req_addr=16'h0800 -> rsp_err=1, rsp_instr=16'hF000.
REQ-036 Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_instr stable; req_ready=0 throughout; on rsp_ready=1, return to IDLE.
REQ-037 Word 4 = 16'hAAAA; on the acceptance edge write ld_addr=4, ld_data=16'h5555 -> response 16'hAAAA; next fetch of word 4 -> 16'h5555.
REQ-038 Assert rst_n=0 in WAIT -> outputs 0 asynchronously; after release, no rsp_valid until a new request.
REQ-039 Under IMEM_ALIGN_CHECK_EN, request req_addr=16'h0003 -> rsp_err=1, rsp_instr=16'hF000; without the macro -> the word-1 contents with rsp_err=0.
